// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: shared state encoding and default counter width for the loop sequencer
package loop_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int N_DEF = 6;
endpackage

// File: rtl/loop_sequencer.sv
// loop_sequencer: loads an up-counter with ~L, issues L step beats, pulses done, flags co disagreement
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] len,
  input  logic         abort,
  output logic         step_valid,
  input  logic         step_ready,
  output logic [N-1:0] iter_idx,
  output logic         cnt_ld,
  output logic [N-1:0] cnt_init,
  output logic         cnt_en,
  input  logic         cnt_co,
  output logic         busy,
  output logic         done,
  output logic         err
);
  state_t state;
  logic [N-1:0] len_q;
  logic at_end;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign cnt_ld = state == LOAD;
  assign cnt_init = cnt_ld ? ~len_q : '0;
  assign step_valid = state == RUN && !cnt_co;
  assign cnt_en = step_valid && step_ready;
  assign at_end = iter_idx == len_q;
  // RUN exits on co or on the shadow index reaching L; any disagreement between the two is an error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      iter_idx <= '0;
      err <= 1'b0;
    end else if (abort && busy) begin
      state <= IDLE;
    end else begin
      if (cnt_en) iter_idx <= iter_idx + 1'b1;
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          err <= 1'b0;
          iter_idx <= '0;
          state <= len == '0 ? DONE : LOAD;
        end
        LOAD: state <= RUN;
        RUN: if (cnt_co || at_end) begin
          state <= DONE;
          err <= err || (cnt_co != at_end);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: directed checks of loop_sequencer against a behavioural loadable counter
module tb_loop_sequencer;
  localparam int N = 6;
  logic clk = 0, rst = 0, start = 0, abort = 0, step_ready = 0, fault = 0;
  logic [N-1:0] len = '0;
  logic step_valid, cnt_ld, cnt_en, cnt_co, busy, done, err;
  logic [N-1:0] iter_idx, cnt_init, q;
  logic [7:0] incs;
  int checks = 0, errors = 0;

  loop_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .step_valid(step_valid), .step_ready(step_ready), .iter_idx(iter_idx),
    .cnt_ld(cnt_ld), .cnt_init(cnt_init), .cnt_en(cnt_en), .cnt_co(cnt_co),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // attached counter; in fault mode co rises early after two increments
  always @(posedge clk) begin
    if (rst) begin q <= '0; incs <= '0; end
    else if (cnt_ld) begin q <= cnt_init; incs <= '0; end
    else if (cnt_en) begin q <= q + 1'b1; incs <= incs + 1'b1; end
  end
  assign cnt_co = fault ? (incs == 8'd2) : (q == '1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); rst = 0;
    checks++;
    if ({busy, done, step_valid, cnt_ld, cnt_en, err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, step_valid, cnt_ld, cnt_en, err});
    end
    checks++;
    if (iter_idx !== 6'd0 || cnt_init !== 6'd0) begin
      errors++; $display("FAIL reset_data got idx=%0d init=%0d want 0 0", iter_idx, cnt_init);
    end
  endtask

  task automatic test_basic();
    step_ready = 1; start = 1; len = 6'd5;
    tick(); start = 0;
    checks++;
    if (cnt_ld !== 1'b1 || cnt_init !== 6'd58 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_load got ld=%b init=%0d busy=%b want 1 58 1", cnt_ld, cnt_init, busy);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      checks++;
      if (step_valid !== 1'b1 || cnt_en !== 1'b1 || cnt_ld !== 1'b0 || iter_idx !== 6'(c - 2)) begin
        errors++; $display("FAIL basic_beat c%0d got v=%b en=%b ld=%b idx=%0d want 1 1 0 %0d", c, step_valid, cnt_en, cnt_ld, iter_idx, c - 2);
      end
    end
    tick();
    checks++;
    if (step_valid !== 1'b0 || cnt_co !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_co got v=%b co=%b done=%b want 0 1 0", step_valid, cnt_co, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_done got done=%b err=%b busy=%b want 1 0 1", done, err, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_zero();
    start = 1; len = 6'd0;
    tick(); start = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || cnt_ld !== 1'b0 || step_valid !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b ld=%b v=%b want 1 1 0 0", done, busy, cnt_ld, step_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL zero_after got busy=%b err=%b done=%b want 0 0 0", busy, err, done);
    end
  endtask

  task automatic test_stall();
    int hs = 0, ens = 0, bad_en = 0, last_hs = -1, done_c = -1;
    start = 1; len = 6'd3; step_ready = 0;
    tick(); start = 0;
    for (int c = 2; c < 40 && done_c < 0; c++) begin
      tick();
      step_ready = c[0];
      #1;
      if (step_valid && step_ready) begin hs++; last_hs = c; end
      if (cnt_en) ens++;
      if (cnt_en && !step_ready) bad_en++;
      if (done) done_c = c;
    end
    checks++;
    if (hs != 3 || ens != 3 || bad_en != 0) begin
      errors++; $display("FAIL stall_hs got hs=%0d en=%0d bad=%0d want 3 3 0", hs, ens, bad_en);
    end
    checks++;
    if (done_c < 0 || done_c != last_hs + 2 || err !== 1'b0 || iter_idx !== 6'd3) begin
      errors++; $display("FAIL stall_done got done_c=%0d last_hs=%0d err=%b idx=%0d want last_hs+2 0 3", done_c, last_hs, err, iter_idx);
    end
    step_ready = 1;
    tick();
  endtask

  task automatic test_fault();
    fault = 1; start = 1; len = 6'd4;
    tick(); start = 0;
    tick(); tick(); tick();
    checks++;
    if (cnt_co !== 1'b1 || step_valid !== 1'b0 || iter_idx !== 6'd2) begin
      errors++; $display("FAIL fault_co got co=%b v=%b idx=%0d want 1 0 2", cnt_co, step_valid, iter_idx);
    end
    tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL fault_done got done=%b err=%b want 1 1", done, err);
    end
    fault = 0;
    tick(); tick(); tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL fault_sticky got err=%b busy=%b want 1 0", err, busy);
    end
    start = 1; len = 6'd1;
    tick(); start = 0;
    checks++;
    if (err !== 1'b0 || cnt_ld !== 1'b1 || cnt_init !== 6'd62) begin
      errors++; $display("FAIL fault_clear got err=%b ld=%b init=%0d want 0 1 62", err, cnt_ld, cnt_init);
    end
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL fault_rerun got done=%b err=%b want 1 0", done, err);
    end
    tick();
  endtask

  task automatic test_abort();
    int dones = 0;
    start = 1; len = 6'd10;
    tick(); start = 0;
    tick(); tick();
    abort = 1;
    tick(); abort = 0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || step_valid !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b done=%b v=%b want 0 0 0", busy, done, step_valid);
    end
    for (int c = 0; c < 12; c++) begin tick(); if (done) dones++; end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_nodone got dones=%0d busy=%b want 0 0", dones, busy);
    end
    start = 1; len = 6'd1;
    tick(); start = 0;
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL abort_rerun got done=%b err=%b want 1 0", done, err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1; len = 6'd8;
    tick(); start = 0;
    tick(); tick(); tick();
    start = 1; len = 6'd2;
    tick(); start = 0;
    checks++;
    if (iter_idx !== 6'd3 || step_valid !== 1'b1) begin
      errors++; $display("FAIL busy_start got idx=%0d v=%b want 3 1", iter_idx, step_valid);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if ({busy, done, step_valid, cnt_ld, cnt_en, err} !== 6'b0 || iter_idx !== 6'd0) begin
      errors++; $display("FAIL midrun_rst got ctrl=%b idx=%0d want 000000 0", {busy, done, step_valid, cnt_ld, cnt_en, err}, iter_idx);
    end
    start = 1; len = 6'd1;
    tick(); start = 0;
    tick(); tick(); tick();
    start = 1; len = 6'd3;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done got done=%b want 1", done);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL done_start got busy=%b want 0", busy);
    end
    tick(); start = 0;
    checks++;
    if (cnt_ld !== 1'b1 || cnt_init !== 6'd60) begin
      errors++; $display("FAIL b2b_accept got ld=%b init=%0d want 1 60", cnt_ld, cnt_init);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_max();
    int beats = 0, done_c = -1;
    start = 1; len = 6'd63;
    tick(); start = 0;
    checks++;
    if (cnt_ld !== 1'b1 || cnt_init !== 6'd0) begin
      errors++; $display("FAIL max_load got ld=%b init=%0d want 1 0", cnt_ld, cnt_init);
    end
    for (int c = 2; c < 100 && done_c < 0; c++) begin
      tick();
      if (cnt_en) beats++;
      if (done) done_c = c;
    end
    checks++;
    if (beats != 63 || done_c != 66 || err !== 1'b0) begin
      errors++; $display("FAIL max_run got beats=%0d done_c=%0d err=%b want 63 66 0", beats, done_c, err);
    end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_fault();
    test_abort();
    test_back_to_back();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
